// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the sized data-memory controller.
//   - access size codes carried on i_size
//   - FSM state encoding used by dmem_sized_ctrl
//   - number of byte lanes in a memory word
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational lane handling for one memory word.
//   Store side: byte enables and write data placed on the addressed lanes.
//   Load side : byte/half extraction at the lane plus sign/zero extension.
//   Also flags misaligned halves/words and the reserved size code.
// Ports:
//   i_size     access size (SZ_BYTE/SZ_HALF/SZ_WORD, 11 reserved)
//   i_signed   load extension select (1 = sign, 0 = zero)
//   i_lane     byte address bits [1:0]
//   i_wdata    right-justified store data
//   i_rword    current contents of the addressed word
//   o_be       per-lane write enables (lane 0 = bits [7:0])
//   o_wdata    store data replicated so every enabled lane sees its bytes
//   o_rdata    extended load result
//   o_misalign access is misaligned or uses the reserved size
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    logic signed [7:0] sb;
    sb = b;
    if (sgn) ext8 = 32'($signed(sb));
    else     ext8 = {24'b0, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    logic signed [15:0] sh;
    sh = h;
    if (sgn) ext16 = 32'($signed(sh));
    else     ext16 = {16'b0, h};
  endfunction

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    rd_byte    = i_rword[{i_lane, 3'b000} +: 8];
    rd_half    = i_rword[{i_lane[1], 4'b0000} +: 16];
    o_be       = 4'b0000;
    o_wdata    = 32'b0;
    o_rdata    = 32'b0;
    o_misalign = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_lane;
        // Replicating the byte places it on whichever lane is enabled.
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = ext8(rd_byte, i_signed);
      end
      SZ_HALF: begin
        o_misalign = i_lane[0];
        o_be       = i_lane[1] ? 4'b1100 : 4'b0011;
        o_wdata    = {2{i_wdata[15:0]}};
        o_rdata    = ext16(rd_half, i_signed);
      end
      SZ_WORD: begin
        o_misalign = |i_lane;
        o_be       = 4'b1111;
        o_wdata    = i_wdata;
        o_rdata    = i_rword;
      end
      default: begin
        o_misalign = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dmem_sized_ctrl.sv
// dmem_sized_ctrl: MEM-stage data memory with byte/half/word access,
// valid/ready request handshake and a configurable number of wait states.
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   ADDR_W       byte address width
//   WAIT_STATES  extra cycles between accept and completion (0..15)
// Ports:
//   i_clk, i_reset         clock, asynchronous active-high reset
//   i_req_valid/o_req_ready request handshake (ready only in IDLE)
//   i_we, i_size, i_signed store/load, access size, load extension
//   i_address, i_writeData byte address, right-justified store data
//   o_readData             extended load data (0 for stores/faults)
//   o_done                 one-cycle completion pulse
//   o_fault                qualifies o_done: the access was suppressed
// Build option:
//   DMEM_BOUNDS_CHECK_EN   when defined, addresses beyond the array fault
//                          instead of wrapping modulo the depth.
module dmem_sized_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_we,
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [31:0]       i_writeData,
  output logic [31:0]       o_readData,
  output logic              o_done,
  output logic              o_fault
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              fault_q, fault_d;

  logic [31:0]       mem [DEPTH_WORDS];

  logic              accept;
  logic              enter_resp;
  logic              sel_we;
  logic [1:0]        sel_size;
  logic              sel_signed;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [IDX_W-1:0]  word_idx;
  logic [31:0]       rword;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic [31:0]       lane_rdata;
  logic              misalign;
  logic              oob;
  logic              acc_fault;
  logic              mem_we;

  assign o_req_ready = (state_q == ST_IDLE) && !i_reset;
  assign accept      = i_req_valid && o_req_ready;
  assign o_done      = (state_q == ST_RESP);
  assign o_fault     = o_done && fault_q;
  assign o_readData  = rdata_q;

  // With zero wait states the access completes on the accept edge itself,
  // so the live request fields are used; otherwise the captured copies.
  always_comb begin
    if (state_q == ST_IDLE) begin
      sel_we     = i_we;
      sel_size   = i_size;
      sel_signed = i_signed;
      sel_addr   = i_address;
      sel_wdata  = i_writeData;
    end else begin
      sel_we     = we_q;
      sel_size   = size_q;
      sel_signed = signed_q;
      sel_addr   = addr_q;
      sel_wdata  = wdata_q;
    end
  end

  assign word_idx = sel_addr[IDX_W+1:2];
  assign rword    = mem[word_idx];

`ifdef DMEM_BOUNDS_CHECK_EN
  assign oob = |(sel_addr >> (IDX_W + 2));
`else
  // Upper address bits are ignored: accesses wrap modulo the depth.
  logic unused_addr_hi;
  assign unused_addr_hi = |(sel_addr >> (IDX_W + 2));
  assign oob            = 1'b0;
`endif

  dmem_lane_align u_align (
    .i_size     (sel_size),
    .i_signed   (sel_signed),
    .i_lane     (sel_addr[1:0]),
    .i_wdata    (sel_wdata),
    .i_rword    (rword),
    .o_be       (lane_be),
    .o_wdata    (lane_wdata),
    .o_rdata    (lane_rdata),
    .o_misalign (misalign)
  );

  assign acc_fault = misalign || oob;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    fault_d  = fault_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d     = i_we;
          size_d   = i_size;
          signed_d = i_signed;
          addr_d   = i_address;
          wdata_d  = i_writeData;
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);

    // Response data and fault are latched on the same edge as the memory
    // access and then held until the next access completes.
    if (enter_resp) begin
      fault_d = acc_fault;
      rdata_d = (acc_fault || sel_we) ? 32'b0 : lane_rdata;
    end
  end

  assign mem_we = enter_resp && sel_we && !acc_fault && !i_reset;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      rdata_q  <= 32'b0;
      fault_q  <= 1'b0;
      we_q     <= 1'b0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Storage is not reset; only enabled lanes are written.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_be[l]) mem[word_idx][l*8 +: 8] <= lane_wdata[l*8 +: 8];
      end
    end
  end

endmodule
